mem_arbiter: RTL and testbench

- Sits directly downstream of the eviction write buffer (ewb). Arbitrates one physical-memory port between two clients:
  - I-cache line reads.
  - D-side traffic from the ewb: line reads on a miss, and write-backs of evicted lines.
- Each memory transaction is one full 256-bit line. Only one transaction is in flight at a time.
- The granted client's request is latched, driven to memory, and the memory response is routed back to that client only.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arb_select.sv | 32 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and width defaults for the memory-port arbiter.
// Latency: n/a (types only). Backpressure: n/a.
package mem_arb_types;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {CLIENT_I, CLIENT_D} arb_client_t;
  typedef enum logic {OP_READ, OP_WRITE} arb_op_t;

  function automatic arb_state_t serve_state(arb_client_t c);
    return (c == CLIENT_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Client and physical-memory signals for the arbiter; slave = arbiter side.
// Latency: n/a (wiring). Backpressure: requests are held until the matching resp pulse.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arb_select.sv
// Combinational grant picker: fixed D priority, or alternate on contention with MEM_ARB_RR_EN.
// Latency: 0 cycles. Backpressure: none; the FSM only samples the grant in IDLE.
module mem_arb_select
  import mem_arb_types::*;
(
  input  logic        i_req,
  input  logic        d_req,
  input  arb_client_t last_grant,
  output logic        grant_valid,
  output arb_client_t grant_client
);

  always_comb begin
    grant_valid  = i_req | d_req;
    grant_client = CLIENT_I;
    if (d_req && !i_req) begin
      grant_client = CLIENT_D;
    end else if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
      grant_client = (last_grant == CLIENT_D) ? CLIENT_I : CLIENT_D;
`else
      grant_client = CLIENT_D;
`endif
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// One-at-a-time line arbiter (I-cache reads vs ewb reads/write-backs); MEM_ARB_RR_EN selects round-robin.
// Latency: strobe 1 cycle after request, resp same cycle as pmem_resp, one dead cycle between transactions.
// Backpressure: clients hold requests until resp; the loser waits in place while the memory is busy.
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  arb_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              load;
  logic              grant_valid;
  arb_client_t       grant_client;
  arb_client_t       last_grant;

`ifdef MEM_ARB_RR_EN
  arb_client_t last_grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= CLIENT_I;
    end else if (load) begin
      last_grant_q <= grant_client;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = CLIENT_D;
`endif

  mem_arb_select u_select (
    .i_req        (bus.i_read),
    .d_req        (bus.d_read | bus.d_write),
    .last_grant   (last_grant),
    .grant_valid  (grant_valid),
    .grant_client (grant_client)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        // A simultaneous read+write from the ewb is treated as a write-back.
        if (grant_client == CLIENT_D) begin
          addr_q  <= bus.d_address;
          wdata_q <= bus.d_wdata;
          op_q    <= bus.d_write ? OP_WRITE : OP_READ;
        end else begin
          addr_q  <= bus.i_address;
          wdata_q <= '0;
          op_q    <= OP_READ;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = serve_state(grant_client);
          load    = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from state so an async reset drops strobes immediately.
  always_comb begin
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.i_resp       = 1'b0;
    bus.i_rdata      = '0;
    bus.d_resp       = 1'b0;
    bus.d_rdata      = '0;
    if (state_q != IDLE) begin
      bus.pmem_read    = (op_q == OP_READ);
      bus.pmem_write   = (op_q == OP_WRITE);
      bus.pmem_address = addr_q;
      if (op_q == OP_WRITE) begin
        bus.pmem_wdata = wdata_q;
      end
    end
    if (state_q == SERVE_I && bus.pmem_resp) begin
      bus.i_resp  = 1'b1;
      bus.i_rdata = bus.pmem_rdata;
    end
    if (state_q == SERVE_D && bus.pmem_resp) begin
      bus.d_resp = 1'b1;
      if (op_q == OP_READ) begin
        bus.d_rdata = bus.pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter; contention order follows MEM_ARB_RR_EN.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  localparam logic [LINE_W-1:0] DATA_AA = {32{8'hAA}};
  localparam logic [LINE_W-1:0] DATA_WB = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] DATA_55 = {32{8'h55}};
  localparam logic [LINE_W-1:0] DATA_C3 = {32{8'hC3}};
  localparam logic [LINE_W-1:0] DATA_3C = {32{8'h3C}};

  logic clk;
  logic rst;
  int   vectors;
  int   errs;
  logic first_d;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
`ifdef MEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    rst            = 1'b0;
    bus.i_read     = 1'b0;
    bus.i_address  = '0;
    bus.d_read     = 1'b0;
    bus.d_write    = 1'b0;
    bus.d_address  = '0;
    bus.d_wdata    = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp  = 1'b0;

    // Reset state
    step();
    step();
    chk1("rst_pmem_read", bus.pmem_read, 1'b0);
    chk1("rst_pmem_write", bus.pmem_write, 1'b0);
    chka("rst_pmem_address", bus.pmem_address, 32'h0);
    chk1("rst_i_resp", bus.i_resp, 1'b0);
    chk1("rst_d_resp", bus.d_resp, 1'b0);
    rst = 1'b1;
    step();
    chk1("post_rst_pmem_read", bus.pmem_read, 1'b0);

    // Lone I read, memory answers 3 cycles after the strobe
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0100;
    for (int c = 1; c <= 3; c++) begin
      step();
      chk1("i_pmem_read", bus.pmem_read, 1'b1);
      chka("i_pmem_address", bus.pmem_address, 32'h0000_0100);
      chk1("i_resp_early", bus.i_resp, 1'b0);
      chk1("i_d_resp_quiet", bus.d_resp, 1'b0);
    end
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = DATA_AA;
    bus.i_read     = 1'b0;
    #1;
    chk1("i_resp", bus.i_resp, 1'b1);
    chkw("i_rdata", bus.i_rdata, DATA_AA);
    chk1("i_d_resp", bus.d_resp, 1'b0);
    chkw("i_d_rdata", bus.d_rdata, '0);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    chk1("i_idle_read", bus.pmem_read, 1'b0);
    // Stray pmem_resp in IDLE
    bus.pmem_resp = 1'b1;
    #1;
    chk1("idle_stray_i_resp", bus.i_resp, 1'b0);
    chk1("idle_stray_d_resp", bus.d_resp, 1'b0);
    bus.pmem_resp = 1'b0;

    // D write-back, pmem_resp at cycle 2
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_2040;
    bus.d_wdata   = DATA_WB;
    step();
    chk1("wb_c1_write", bus.pmem_write, 1'b1);
    chk1("wb_c1_read", bus.pmem_read, 1'b0);
    chka("wb_c1_address", bus.pmem_address, 32'h0000_2040);
    chkw("wb_c1_wdata", bus.pmem_wdata, DATA_WB);
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = DATA_55;
    bus.d_write    = 1'b0;
    #1;
    chk1("wb_c2_write", bus.pmem_write, 1'b1);
    chkw("wb_c2_wdata", bus.pmem_wdata, DATA_WB);
    chk1("wb_d_resp", bus.d_resp, 1'b1);
    chkw("wb_d_rdata", bus.d_rdata, '0);
    chk1("wb_i_resp", bus.i_resp, 1'b0);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    chk1("wb_c3_write", bus.pmem_write, 1'b0);
    chk1("wb_c3_read", bus.pmem_read, 1'b0);
    chk1("wb_c3_d_resp", bus.d_resp, 1'b0);

    // Contention: both reads together, both held until served
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0300;
    bus.d_read    = 1'b1;
    bus.d_address = 32'h0000_0400;
    step();
    chk1("arb_c1_read", bus.pmem_read, 1'b1);
    chka("arb_first_address", bus.pmem_address, first_d ? 32'h0000_0400 : 32'h0000_0300);
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = DATA_C3;
    if (first_d) bus.d_read = 1'b0;
    else         bus.i_read = 1'b0;
    #1;
    chk1("arb_first_d_resp", bus.d_resp, first_d);
    chk1("arb_first_i_resp", bus.i_resp, !first_d);
    chkw("arb_first_rdata", first_d ? bus.d_rdata : bus.i_rdata, DATA_C3);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    chk1("arb_dead_read", bus.pmem_read, 1'b0);
    step();
    chk1("arb_second_read", bus.pmem_read, 1'b1);
    chka("arb_second_address", bus.pmem_address, first_d ? 32'h0000_0300 : 32'h0000_0400);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = DATA_3C;
    bus.i_read     = 1'b0;
    bus.d_read     = 1'b0;
    #1;
    chk1("arb_second_i_resp", bus.i_resp, first_d);
    chk1("arb_second_d_resp", bus.d_resp, !first_d);
    chkw("arb_second_rdata", first_d ? bus.i_rdata : bus.d_rdata, DATA_3C);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    chk1("arb_idle_read", bus.pmem_read, 1'b0);

    // Reset in the middle of a write-back
    bus.d_write   = 1'b1;
    bus.d_address = 32'h0000_0500;
    bus.d_wdata   = DATA_WB;
    step();
    chk1("rstmid_write_before", bus.pmem_write, 1'b1);
    #2;
    rst           = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    chk1("rstmid_write_dropped", bus.pmem_write, 1'b0);
    chk1("rstmid_no_d_resp", bus.d_resp, 1'b0);
    bus.d_write   = 1'b0;
    bus.pmem_resp = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk1("rstmid_idle", bus.pmem_write, 1'b0);

    // Fresh I read after reset; address changes after grant
    bus.i_read    = 1'b1;
    bus.i_address = 32'h0000_0100;
    step();
    chk1("addr_c1_read", bus.pmem_read, 1'b1);
    chka("addr_c1", bus.pmem_address, 32'h0000_0100);
    bus.i_address = 32'h0000_0200;
    step();
    chka("addr_c2_held", bus.pmem_address, 32'h0000_0100);
    step();
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = DATA_55;
    bus.i_read     = 1'b0;
    #1;
    chka("addr_c3_held", bus.pmem_address, 32'h0000_0100);
    chk1("addr_i_resp", bus.i_resp, 1'b1);
    chkw("addr_i_rdata", bus.i_rdata, DATA_55);
    step();
    bus.pmem_resp = 1'b0;
    #1;
    chk1("addr_idle_read", bus.pmem_read, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
